// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
//
// Receive front end of the UART. Synchronises the asynchronous rx pin,
// generates the oversample tick from a programmable divisor, and runs the
// start / data / parity / stop state machine. Each good byte leaves as a
// single-cycle FIFO write; framing, parity and overrun events leave as
// single-cycle pulses.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8), LSB first
//   PARITY_EN   1 = a parity bit follows the data bits
//   PARITY_ODD  1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
//   OVERSAMPLE  ticks per bit, even and >= 8
//
// Ports:
//   PCLK              system clock, rising edge
//   PRESETn           asynchronous active-low reset
//   baud_final_value  tick divider: one tick every baud_final_value+1 cycles
//   rx                serial input, idle high, asynchronous
//   rx_fifo_Full      RX FIFO full
//   rx_fifo_dataIn    received byte, zero-extended above DATA_BITS
//   rx_fifo_writeEn   one-cycle FIFO write strobe
//   framing_err       one-cycle pulse: stop bit sampled low
//   parity_err        one-cycle pulse: parity mismatch
//   overrun_err       one-cycle pulse: good byte dropped, FIFO full
//   busy              high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_frontend #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [10:0] baud_final_value,
  input  logic        rx,
  input  logic        rx_fifo_Full,
  output logic [7:0]  rx_fifo_dataIn,
  output logic        rx_fifo_writeEn,
  output logic        framing_err,
  output logic        parity_err,
  output logic        overrun_err,
  output logic        busy
);

  // Sample index arithmetic. MID is the nominal bit centre; the three
  // majority samples straddle it and the decision falls on the last one.
  localparam int MID = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] IDX_A    = SW'(MID - 1);
  localparam logic [SW-1:0] IDX_B    = SW'(MID);
  localparam logic [SW-1:0] IDX_DEC  = SW'(MID + 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(OVERSAMPLE - 1);

  localparam logic [3:0] BITS_LAST = 4'(DATA_BITS);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t               state_reg;

  logic                 sync1_reg;
  logic                 rx_s_reg;

  logic [10:0]          div_reg;
  logic [10:0]          tick_cnt_reg;
  logic [SW-1:0]        samp_reg;
  logic                 samp_a_reg;
  logic                 samp_b_reg;

  logic [DATA_BITS-1:0] shift_reg;
  logic [3:0]           bit_cnt_reg;
  logic                 perr_reg;

  logic [7:0]           data_reg;
  logic                 we_reg;
  logic                 fe_reg;
  logic                 pe_reg;
  logic                 oe_reg;

  logic                 start_det;
  logic                 tick;
  logic                 decide;
  logic                 bit_end;
  logic                 maj;
  logic [7:0]           byte_ext;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser; idle-high so reset must not look like a start bit.
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1_reg <= 1'b1;
      rx_s_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rx_s_reg  <= sync1_reg;
    end
  end

  assign start_det = (state_reg == IDLE) && !rx_s_reg;

  // -------------------------------------------------------------------------
  // Tick generator. The divisor is captured at the start edge so that a
  // reprogrammed baud rate only takes effect on the next frame.
  // -------------------------------------------------------------------------
  assign tick = (state_reg != IDLE) && (tick_cnt_reg == div_reg);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      div_reg      <= 11'd0;
      tick_cnt_reg <= 11'd0;
    end else if (start_det) begin
      div_reg      <= baud_final_value;
      tick_cnt_reg <= 11'd0;
    end else if (state_reg != IDLE) begin
      if (tick) begin
        tick_cnt_reg <= 11'd0;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 11'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sample counter: index of the current tick within the bit period. It runs
  // continuously across bit boundaries for the whole frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      samp_reg <= '0;
    end else if (start_det) begin
      samp_reg <= '0;
    end else if (tick) begin
      if (samp_reg == IDX_LAST) begin
        samp_reg <= '0;
      end else begin
        samp_reg <= samp_reg + 1'b1;
      end
    end
  end

  // The first two of the three majority samples are stored; the third is
  // the live rx_s on the decision tick.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      samp_a_reg <= 1'b0;
      samp_b_reg <= 1'b0;
    end else if (tick) begin
      if (samp_reg == IDX_A) samp_a_reg <= rx_s_reg;
      if (samp_reg == IDX_B) samp_b_reg <= rx_s_reg;
    end
  end

  assign decide  = tick && (samp_reg == IDX_DEC);
  assign bit_end = tick && (samp_reg == IDX_LAST);
  assign maj     = (samp_a_reg & samp_b_reg) |
                   (samp_a_reg & rx_s_reg)   |
                   (samp_b_reg & rx_s_reg);

  // Received word zero-extended to the FIFO width.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ext
    if (gi < DATA_BITS) begin : g_bit
      assign byte_ext[gi] = shift_reg[gi];
    end else begin : g_zero
      assign byte_ext[gi] = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Frame state machine with registered outputs. Pulse outputs default low
  // every cycle so each event lasts exactly one cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= 4'd0;
      perr_reg    <= 1'b0;
      data_reg    <= 8'd0;
      we_reg      <= 1'b0;
      fe_reg      <= 1'b0;
      pe_reg      <= 1'b0;
      oe_reg      <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      fe_reg <= 1'b0;
      pe_reg <= 1'b0;
      oe_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            state_reg   <= START;
            bit_cnt_reg <= 4'd0;
            perr_reg    <= 1'b0;
          end
        end

        START: begin
          // A start bit that is high at its centre was a glitch.
          if (decide && maj) begin
            state_reg <= IDLE;
          end else if (bit_end) begin
            state_reg   <= DATA;
            bit_cnt_reg <= 4'd0;
          end
        end

        DATA: begin
          if (decide) begin
            shift_reg   <= {maj, shift_reg[DATA_BITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
          // The count was bumped at the decision, so it already equals
          // DATA_BITS at the end of the last data bit.
          if (bit_end && (bit_cnt_reg == BITS_LAST)) begin
            state_reg <= PAR_EN ? PARITY : STOP;
          end
        end

        PARITY: begin
          if (decide) begin
            perr_reg <= ((^shift_reg) ^ maj) != PAR_ODD;
          end
          if (bit_end) begin
            state_reg <= STOP;
          end
        end

        STOP: begin
          // Leaving at the stop-bit centre leaves half a bit of margin to
          // catch a back-to-back start edge.
          if (decide) begin
            if (maj) begin
              state_reg <= IDLE;
              pe_reg    <= perr_reg;
              if (rx_fifo_Full) begin
                oe_reg <= 1'b1;
              end else begin
                we_reg   <= 1'b1;
                data_reg <= byte_ext;
              end
            end else begin
              state_reg <= BREAK;
              fe_reg    <= 1'b1;
            end
          end
        end

        BREAK: begin
          // Hold off until the line idles so a held-low line is one error.
          if (rx_s_reg) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rx_fifo_dataIn  = data_reg;
  assign rx_fifo_writeEn = we_reg;
  assign framing_err     = fe_reg;
  assign parity_err      = pe_reg;
  assign overrun_err     = oe_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Receive front end of the UART: consumes the asynchronous `rx` pin and produces bytes into the RX FIFO write port, which the APB interface later drains.
- Synchronises `rx`, generates the 16x oversample tick from `baud_final_value`, and runs the start/data/parity/stop state machine.
- Writes each good byte as a one-cycle FIFO write.
- Reports framing, parity and overrun events as single-cycle pulses.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- OVERSAMPLE, 16, ticks per bit; must be even and >= 8.

Ports:
- PCLK  in  1  system clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- baud_final_value  in  11  tick divider; one tick every baud_final_value+1 PCLK cycles.
- rx  in  1  serial input, idle high, asynchronous.
- rx_fifo_Full  in  1  RX FIFO full.
- rx_fifo_dataIn  out  8  received byte, zero-extended above DATA_BITS.
- rx_fifo_writeEn  out  1  one-cycle FIFO write strobe.
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun_err  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (asynchronous, PRESETn low):
  - Synchroniser flops = 1.
  - State = IDLE.
  - Tick and sample counters = 0.
  - Shift register = 0.
  - All outputs = 0.
- Reset mid-frame aborts immediately with no write and no error pulse.
- Synchroniser: two flops; `rx_s` is the second flop. All decisions use `rx_s`, so there is 2 cycles of pin-to-logic latency.
- Tick generator:
  - 11-bit counter; `tick` asserts for one cycle when count == latched divisor, and the count then returns to 0.
  - Divisor is latched from `baud_final_value` on start detection; changes mid-frame have no effect.
  - baud_final_value=0 gives a tick every cycle.
- Sample counter: 0..OVERSAMPLE-1, advances on `tick`, wraps at the bit boundary.
- Bit value = majority of `rx_s` at sample indices M-1, M, M+1, where M = OVERSAMPLE/2 (default 7, 8, 9).
  - The decision is taken on the tick at index M+1.
- States:
  - IDLE: when `rx_s`==0, go to START; clear the tick and sample counters; latch the divisor.
  - START: at index M+1, majority==1 → glitch, return to IDLE with no output. Otherwise continue to index OVERSAMPLE-1, then go to DATA with bit count 0.
  - DATA: at each bit decision, shift right into the register (first received bit ends up in bit 0). After DATA_BITS bits, at index OVERSAMPLE-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: at the decision, perr = (XOR of data bits XOR received bit) != PARITY_ODD. At index OVERSAMPLE-1, go to STOP.
  - STOP: the decision tick ends the frame. All outputs assert on the cycle after the decision tick, for exactly one cycle.
    - Stop=1, FIFO not full: assert `rx_fifo_writeEn` with the byte; assert `parity_err` in the same cycle if perr (the byte is still written). Go to IDLE.
    - Stop=1, `rx_fifo_Full`=1 (sampled at the decision tick): no write; assert `overrun_err`, plus `parity_err` if perr. Go to IDLE.
    - Stop=0: no write; assert `framing_err` (`parity_err` is suppressed). Go to BREAK.
  - BREAK: wait until `rx_s`==1, then go to IDLE. This prevents a held-low line from retriggering.
- Leaving STOP at the mid-stop decision gives half a bit of resync margin. Back-to-back frames are received with no lost start edge.
- Latency: with D = baud_final_value+1, `rx_fifo_writeEn` asserts (OVERSAMPLE·(1+DATA_BITS+PARITY_EN) + M+2)·D + 1 cycles after `rx_s` first reads 0.
  - Default 8N1: (16·9+10)·D + 1 cycles.
- `rx_fifo_dataIn` holds its last value between writes.

Test Plan:
- Reset: PRESETn low with rx toggling → all outputs 0, busy 0; release → still 0 while rx=1.
- baud_final_value=3, send 0xA5 in 8N1 (64 cycles/bit) → exactly one writeEn, data 0xA5, at the computed latency; no error pulses; busy falls with writeEn.
- rx low for 20 cycles, then high (baud 3) → no writeEn and no errors; busy returns to 0; a following 0x3C frame is received correctly.
- 0x3C with stop bit driven 0 for 3 bit times → framing_err pulse only, no writeEn; busy stays high until rx returns high.
- rx_fifo_Full=1 during 0x5A → overrun_err pulse, no writeEn. Repeat with PARITY_EN=1, even parity, wrong parity bit, FIFO not full → writeEn with 0x5A plus parity_err in the same cycle.
- PRESETn pulsed low mid data bit 4 → busy and outputs go to 0 immediately with no write; next frame 0x81 → written as 0x81.
